// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Drives the control inputs of an N-bit universal up/down counter. It runs
//   one-shot countdowns, periodic reload timers, full up-counts and
//   continuous triangle sweeps. A host loads mode/value/divisor through a
//   valid/ready handshake.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   cfg_valid    host command valid
//   cfg_ready    command accepted (high only while idle)
//   cfg_mode     00 oneshot down, 01 periodic down, 10 up to max, 11 triangle
//   cfg_value    start / reload value for the down modes
//   cfg_div      counter advances once every cfg_div+1 cycles
//   stop         abort the running sequence
//   cnt_max_tick counter flag, q == all ones
//   cnt_min_tick counter flag, q == 0
//   cnt_en       counter count enable
//   cnt_up       counter direction (1 = up)
//   cnt_d        counter load data
//   cnt_syn_clr  counter synchronous clear
//   cnt_load     counter synchronous load
//   busy         sequence in progress (LOAD or RUN)
//   done         one-cycle pulse, one-shot sequence finished
//   evt          one-cycle pulse, periodic reload or triangle turn
module counter_sequencer #(
  parameter int N          = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_mode,
  input  logic [N-1:0]          cfg_value,
  input  logic [PRESCALE_W-1:0] cfg_div,
  input  logic                  stop,
  input  logic                  cnt_max_tick,
  input  logic                  cnt_min_tick,
  output logic                  cnt_en,
  output logic                  cnt_up,
  output logic [N-1:0]          cnt_d,
  output logic                  cnt_syn_clr,
  output logic                  cnt_load,
  output logic                  busy,
  output logic                  done,
  output logic                  evt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [1:0] M_ONESHOT  = 2'b00;
  localparam logic [1:0] M_PERIODIC = 2'b01;
  localparam logic [1:0] M_UPMAX    = 2'b10;
  localparam logic [1:0] M_TRI      = 2'b11;

  logic [1:0]            state_r, state_nx;
  logic [1:0]            mode_r;
  logic [N-1:0]          value_r;
  logic [PRESCALE_W-1:0] div_r;
  logic [PRESCALE_W-1:0] pre_r;
  logic                  dir_r;

  logic strobe;
  logic terminal;
  logic turn;
  logic down_mode;

  assign down_mode = ~mode_r[1];
  assign strobe    = (state_r == S_RUN) && (pre_r == div_r);
  assign terminal  = dir_r ? cnt_max_tick : cnt_min_tick;

  always_comb begin
    state_nx    = state_r;
    cfg_ready   = 1'b0;
    cnt_en      = 1'b0;
    cnt_syn_clr = 1'b0;
    cnt_load    = 1'b0;
    done        = 1'b0;
    evt         = 1'b0;
    turn        = 1'b0;
    case (state_r)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_nx = S_LOAD;
      end
      S_LOAD: begin
        if (stop) begin
          state_nx = S_IDLE;
        end else begin
          cnt_load    = down_mode;
          cnt_syn_clr = ~down_mode;
          state_nx    = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nx = S_IDLE;
        end else if (strobe) begin
          if (!terminal) begin
            cnt_en = 1'b1;
          end else begin
            case (mode_r)
              M_ONESHOT, M_UPMAX: begin
                done     = 1'b1;
                state_nx = S_IDLE;
              end
              M_PERIODIC: begin
                cnt_load = 1'b1;
                evt      = 1'b1;
              end
              M_TRI: begin
                turn   = 1'b1;
                cnt_en = 1'b1;
                evt    = 1'b1;
              end
              default: state_nx = S_IDLE;
            endcase
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // On a triangle turn the counter must already step in the new direction,
  // so the flipped direction is presented in the same cycle it is registered.
  assign cnt_up = dir_r ^ turn;
  assign cnt_d  = value_r;
  assign busy   = (state_r == S_LOAD) || (state_r == S_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      mode_r  <= 2'b00;
      value_r <= '0;
      div_r   <= '0;
      pre_r   <= '0;
      dir_r   <= 1'b0;
    end else begin
      state_r <= state_nx;
      case (state_r)
        S_IDLE: begin
          if (cfg_valid) begin
            mode_r  <= cfg_mode;
            value_r <= cfg_value;
            div_r   <= cfg_div;
          end
        end
        S_LOAD: begin
          dir_r <= mode_r[1];
          pre_r <= '0;
        end
        S_RUN: begin
          pre_r <= strobe ? '0 : pre_r + PRESCALE_W'(1);
          if (turn) dir_r <= ~dir_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

  localparam int N  = 4;
  localparam int PW = 3;
  localparam int P  = (1 << N) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_mode;
  logic [N-1:0]  cfg_value;
  logic [PW-1:0] cfg_div;
  logic          stop;
  logic          cnt_max_tick;
  logic          cnt_min_tick;
  logic          cnt_en;
  logic          cnt_up;
  logic [N-1:0]  cnt_d;
  logic          cnt_syn_clr;
  logic          cnt_load;
  logic          busy;
  logic          done;
  logic          evt;

  logic [N-1:0]  q;

  int vectors = 0;
  int fails   = 0;
  bit           hold_chk = 1'b0;
  logic [N-1:0] held_q   = '0;

  counter_sequencer #(.N(N), .PRESCALE_W(PW)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_value(cfg_value), .cfg_div(cfg_div), .stop(stop),
    .cnt_max_tick(cnt_max_tick), .cnt_min_tick(cnt_min_tick),
    .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_d(cnt_d), .cnt_syn_clr(cnt_syn_clr),
    .cnt_load(cnt_load), .busy(busy), .done(done), .evt(evt)
  );

  always #5 clk = ~clk;

  // Attached universal counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           q <= '0;
    else if (cnt_syn_clr) q <= '0;
    else if (cnt_load)    q <= cnt_d;
    else if (cnt_en)      q <= cnt_up ? q + 4'd1 : q - 4'd1;
  end
  assign cnt_max_tick = (q == '1);
  assign cnt_min_tick = (q == '0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_ctl"},   {29'd0, cnt_en, cnt_load, cnt_syn_clr}, 32'd0);
    chk({tag, "_pulse"}, {30'd0, done, evt}, 32'd0);
  endtask

  // Expected behaviour is derived from the timing rules: the strobe k lands at
  // A + 1 + (k+1)(div+1), and q at each strobe follows the mode's sequence.
  task automatic run_cmd(input int mode, input int v, input int d,
                         input int stop_t, input int rst_t);
    int  span   = d + 1;
    bit  down   = (mode < 2);
    int  done_t = (mode == 0) ? 1 + (v + 1) * span :
                  (mode == 2) ? 1 + (P + 1) * span : 1 << 30;
    int  t_last = (stop_t >= 0 && stop_t < done_t) ? stop_t : done_t;
    bit  aborted = 1'b0;
    logic [N-1:0] q_stop = '0;
    for (int t = 0; t <= t_last && !aborted; t++) begin
      bit e_en = 0, e_ld = 0, e_clr = 0, e_done = 0, e_evt = 0;
      int e_up = -1;
      int e_q  = -1;
      cfg_valid = (t == 0);
      cfg_mode  = 2'(mode);
      cfg_value = N'(v);
      cfg_div   = PW'(d);
      stop      = (t == stop_t);
      #3;
      if (t == 0) begin
        if (hold_chk) chk("q_hold_after_stop", 32'(q), 32'(held_q));
        hold_chk = 1'b0;
      end else if (t == stop_t) begin
        q_stop = q;
      end else if (t == 1) begin
        e_ld  = down;
        e_clr = !down;
      end else begin
        int k  = (t - 1) / span - 1;
        bit st = ((t - 1) % span == 0);
        if (mode == 3) e_up = (k < 0) ? 1 : (((k / P) % 2) == 0);
        else           e_up = down ? 0 : 1;
        if (st) begin
          case (mode)
            0: begin e_q = v - k;           if (k < v) e_en = 1; else e_done = 1; end
            1: begin e_q = v - k % (v + 1); if (k % (v + 1) == v) begin e_ld = 1; e_evt = 1; end else e_en = 1; end
            2: begin e_q = k;               if (k < P) e_en = 1; else e_done = 1; end
            default: begin
              int m = k % (2 * P);
              e_q   = (m <= P) ? m : 2 * P - m;
              e_en  = 1;
              e_evt = (k > 0) && (k % P == 0);
            end
          endcase
        end
      end
      chk("cfg_ready", 32'(cfg_ready), 32'(t == 0));
      chk("busy", 32'(busy), 32'(t > 0));
      chk("cnt_en", 32'(cnt_en), 32'(e_en));
      chk("cnt_load", 32'(cnt_load), 32'(e_ld));
      chk("cnt_syn_clr", 32'(cnt_syn_clr), 32'(e_clr));
      chk("done", 32'(done), 32'(e_done));
      chk("evt", 32'(evt), 32'(e_evt));
      if (t >= 1) chk("cnt_d", 32'(cnt_d), 32'(v));
      if (e_up >= 0 && t != stop_t) chk("cnt_up", 32'(cnt_up), 32'(e_up));
      if (e_q >= 0) chk("q", 32'(q), 32'(e_q));
      if (t == rst_t) begin
        #2 reset = 1'b0;
        #1 chk_idle("async_reset");
        @(posedge clk); #1;
        chk_idle("in_reset");
        #2 reset = 1'b1;
        aborted = 1'b1;
      end
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    stop      = 1'b0;
    if (!aborted && stop_t >= 0 && stop_t < done_t) begin
      hold_chk = 1'b1;
      held_q   = q_stop;
    end
  endtask

  initial begin
    reset = 1'b0;
    cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_value = '0; cfg_div = '0; stop = 1'b0;
    #3;
    chk_idle("reset_state");
    chk("reset_cnt_d", 32'(cnt_d), 32'd0);
    #9 reset = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_cmd(0, 3, 0, -1, -1);   // oneshot V=3 D=0, done at A+5
    run_cmd(1, 2, 1, 26, -1);   // periodic V=2 D=1, evt every 6 from A+7
    run_cmd(3, 5, 0, 70, -1);   // triangle, two full sweeps
    run_cmd(2, 9, 0, -1, -1);   // up to max, done at A+17
    run_cmd(0, 2, 1, 7, -1);    // stop on the terminal strobe
    run_cmd(0, 4, 0, 2, -1);    // stop, then next command accepted at once
    run_cmd(2, 0, 1, 1, -1);    // stop during LOAD
    run_cmd(0, 6, 1, -1, 6);    // asynchronous reset mid-run
    run_cmd(0, 1, 0, -1, -1);   // oneshot V=1 D=0 after reset, done at A+3
    run_cmd(0, 0, 2, -1, -1);   // V=0 boundary

    // Randomized commands
    for (int i = 0; i < 20; i++) begin
      int m  = $urandom_range(0, 3);
      int v  = $urandom_range(0, 5);
      int d  = $urandom_range(0, 3);
      int st = -1;
      if (m == 1 || m == 3)          st = $urandom_range(2, 60);
      else if ($urandom_range(0, 1)) st = $urandom_range(1, 30);
      run_cmd(m, v, d, st, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
